// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell used by the serial adder datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell steps LSB-first through WIDTH bits.
//
// state  | meaning
// IDLE   | waiting for start; operands captured on the accepting edge
// SHIFT  | one bit per cycle through the full_adder, WIDTH cycles
// FINISH | result registered; returns to IDLE next edge
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  // busy/done are registered views of the state, so they trail it by one
  // cycle; this is what gives the WIDTH+1 done latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      busy <= (state == SHIFT);
      done <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            carry  <= cin;
            cnt    <= '0;
            res_sr <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          res_sr <= {fa_s, res_sr[WIDTH-1:1]};
          carry  <= fa_co;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + CW'(1);
          // Last bit: publish the assembled word directly from the cell output.
          if (cnt == LAST_BIT) begin
            sum   <= {fa_s, res_sr[WIDTH-1:1]};
            cout  <= fa_co;
            state <= FINISH;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 and WIDTH=4 instances).
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       cin4 = 1'b0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] model_sum = '0;
  logic       model_cout = 1'b0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b, required all 0", busy, done, sum, cout);
    end
    tests_run++;
    if ({busy4, done4, sum4, cout4} !== 7'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs_w4: busy=%b done=%b sum=%h cout=%b, required all 0", busy4, done4, sum4, cout4);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_sum = '0;
    model_cout = 1'b0;
  endtask

  // One complete operation on the 8-bit instance; optionally re-pulses start
  // with junk operands while the operation is in flight.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input bit poke_start, input string name);
    logic [8:0] full;
    int done_edge, busy_cnt, done_cnt;
    full = {1'b0, av} + {1'b0, bv} + 9'(cv);
    @(negedge clk);
    start = 1'b1; a = av; b = bv; cin = cv;
    @(posedge clk);
    #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    busy_cnt = 0; done_cnt = 0; done_edge = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = k;
      end
      if (k == 2) begin
        tests_run++;
        if (sum !== model_sum || cout !== model_cout) begin
          tests_failed++;
          $display("FAIL %s_hold: sum=%h cout=%b mid-op, required previous %h/%b", name, sum, cout, model_sum, model_cout);
        end
        if (poke_start) begin
          start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        end
      end
      if (k == 4) start = 1'b0;
    end
    tests_run++;
    if (done_edge != 9) begin
      tests_failed++;
      $display("FAIL %s_latency: done at edge %0d, required edge 9", name, done_edge);
    end
    tests_run++;
    if (done_cnt != 1) begin
      tests_failed++;
      $display("FAIL %s_done_pulses: %0d pulses, required 1", name, done_cnt);
    end
    tests_run++;
    if (busy_cnt != 8) begin
      tests_failed++;
      $display("FAIL %s_busy_cycles: %0d, required 8", name, busy_cnt);
    end
    tests_run++;
    if (sum !== full[7:0] || cout !== full[8]) begin
      tests_failed++;
      $display("FAIL %s_result: %h+%h+%b gave sum=%h cout=%b, required sum=%h cout=%b",
               name, av, bv, cv, sum, cout, full[7:0], full[8]);
    end
    model_sum = full[7:0];
    model_cout = full[8];
  endtask

  task automatic test_basic();
    run_op(8'd3, 8'd5, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_carry_out();
    run_op(8'd255, 8'd1, 1'b0, 1'b0, "carry_out");
  endtask

  task automatic test_carry_in();
    run_op(8'h7F, 8'h00, 1'b1, 1'b0, "carry_in");
  endtask

  task automatic test_ignored_start();
    run_op(8'd100, 8'd27, 1'b0, 1'b1, "ignored_start");
  endtask

  task automatic test_reset_abort();
    int done_cnt;
    @(negedge clk);
    start = 1'b1; a = 8'd200; b = 8'd100; cin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_abort_outputs: busy=%b done=%b sum=%h cout=%b, required all 0", busy, done, sum, cout);
    end
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
      if (k == 1) begin
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    tests_run++;
    if (done_cnt != 0) begin
      tests_failed++;
      $display("FAIL reset_abort_no_done: %0d done pulses, required 0", done_cnt);
    end
    model_sum = '0;
    model_cout = 1'b0;
    run_op(8'd10, 8'd20, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), "random");
  endtask

  task automatic test_back_to_back();
    int done_edges[$];
    int bad_res;
    bad_res = 0;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd9; cin4 = 1'b0;
    for (int k = 0; k <= 24; k++) begin
      @(posedge clk);
      #1;
      if (done4) begin
        done_edges.push_back(k);
        if (sum4 !== 4'd2 || cout4 !== 1'b1) bad_res++;
      end
    end
    start4 = 1'b0;
    tests_run++;
    if (done_edges.size() != 4) begin
      tests_failed++;
      $display("FAIL b2b_count: %0d done pulses in 25 edges, required 4", done_edges.size());
    end
    tests_run++;
    if (done_edges.size() == 0 || done_edges[0] != 5) begin
      tests_failed++;
      $display("FAIL b2b_first_latency: first done at edge %0d, required 5",
               done_edges.size() == 0 ? -1 : done_edges[0]);
    end
    for (int i = 1; i < done_edges.size(); i++) begin
      tests_run++;
      if (done_edges[i] - done_edges[i-1] != 6) begin
        tests_failed++;
        $display("FAIL b2b_period: gap %0d, required 6", done_edges[i] - done_edges[i-1]);
      end
    end
    tests_run++;
    if (bad_res != 0) begin
      tests_failed++;
      $display("FAIL b2b_result: %0d wrong results, required sum=2 cout=1 each time", bad_res);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_out();
    test_carry_in();
    test_ignored_start();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit, the request to begin an addition, sampled on a rising clk edge.
REQ-005 The block SHALL have port a, input, WIDTH bits, operand A, captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits, operand B, captured when start is accepted.
REQ-007 The block SHALL have port cin, input, 1 bit, the carry-in, captured when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit, high while bits are being shifted.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking sum and cout valid.
REQ-010 The block SHALL have port sum, output, WIDTH bits, the result of a+b+cin modulo 2^WIDTH.
REQ-011 The block SHALL have port cout, output, 1 bit, the final carry out of the MSB.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, SHIFT and FINISH.
REQ-013 In IDLE, start=1 SHALL be accepted, with these actions on the same edge:
- load a and b into internal shift registers;
- load cin into the carry flip-flop;
- clear the bit counter and the result shift register;
- go to SHIFT.
REQ-014 In SHIFT, each cycle SHALL perform one bit step:
- feed the LSBs of the A and B registers plus the carry flip-flop into one full_adder cell;
- shift the cell's S into the MSB of the result register (LSB-first assembly);
- register the cell's Cout into the carry flip-flop;
- shift the A and B registers right by one;
- increment the counter.
REQ-015 After exactly WIDTH SHIFT cycles the FSM SHALL go to FINISH; in FINISH done=1 for one cycle, then the FSM SHALL return to IDLE.
REQ-016 Latency SHALL be fixed: with start accepted at edge 0, done SHALL be high in the cycle following edge WIDTH+1.
REQ-017 busy SHALL be 1 exactly in SHIFT and 0 in IDLE and FINISH.
REQ-018 sum and cout SHALL update only on the edge entering FINISH, and SHALL hold stable until the next completed operation.
REQ-019 start SHALL be ignored in SHIFT and FINISH; no queuing, and operands presented then SHALL be discarded.
REQ-020 start held high continuously SHALL produce back-to-back operations, one every WIDTH+2 cycles.
REQ-021 Wrap-around SHALL be handled as follows:
- sum wraps modulo 2^WIDTH;
- cout=1 exactly when a+b+cin >= 2^WIDTH;
- the bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never wrap within an operation.
REQ-022 Operand inputs SHALL be don't-care outside the accepting edge.

Reset
REQ-023 rst_n=0 SHALL immediately, without a clock, force all of the following:
- the state to IDLE;
- busy=0, done=0, sum=0, cout=0;
- the counter, the carry flip-flop and the operand registers to 0.
REQ-024 Reset asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow, and the first start accepted after rst_n rises SHALL proceed normally.

Structure
REQ-025 The state encodings (IDLE=2'd0, SHIFT=2'd1, FINISH=2'd2) SHALL reside in shared package serial_adder_pkg; WIDTH SHALL stay a module parameter.
REQ-026 The block SHALL instantiate the existing full_adder cell exactly once as its only sub-module; no other arithmetic operator SHALL generate sum.

Verification
REQ-027 The bench SHALL cover these directed scenarios (all at WIDTH=8 except the last):
- Basic add: a=3, b=5, cin=0, start pulse at edge 0 -> busy high for 8 cycles, done in the cycle after edge 9, sum=8, cout=0.
- Carry out: a=255, b=1, cin=0 -> sum=0, cout=1.
- Carry in: a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0.
- Ignored start: start re-pulsed with a=0xFF, b=0xFF during busy -> first result unchanged, exactly one done pulse.
- Reset abort: rst_n low at SHIFT cycle 4 -> all outputs 0 at once, no done; then a=10, b=20 -> sum=30.
- Continuous start, WIDTH=4: a=9, b=9 -> done every 6 cycles, sum=2, cout=1.
